audio_mix_seq: RTL

Sequential mixer/scheduler between the PSG/PCM sources and the I2S DAC interface in the audio block. On each next_sample strobe it snapshots the four 16-bit source samples and two 4-bit volumes. It then computes left = sat(psg_l*psg_vol + pcm_l*pcm_vol) and right = sat(psg_r*psg_vol + pcm_r*pcm_vol) using one shared shift-add multiplier/accumulator. Finally it presents 24-bit left/right words for dacif.

---
 rtl/audio_mix_seq.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/audio_mix_seq.sv
// Sequential PSG/PCM mixer: snapshots sources on next_sample, scales and sums each
// channel with one shared shift-add MAC, saturates, and presents 24-bit DAC words.
module audio_mix_seq #(
  parameter int unsigned VOL_SHIFT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        next_sample,
  input  logic [15:0] psg_left,
  input  logic [15:0] psg_right,
  input  logic [15:0] pcm_left,
  input  logic [15:0] pcm_right,
  input  logic [3:0]  psg_volume,
  input  logic [3:0]  pcm_volume,
  input  logic        ovr_clear,
  output logic [23:0] left_data,
  output logic [23:0] right_data,
  output logic        sample_valid,
  output logic        busy,
  output logic        overrun
);

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned VOL_W    = 4;
  localparam int unsigned ACC_W    = 21;
  localparam int unsigned SAT_W    = 17;
  localparam int unsigned OUT_W    = 24;
  localparam int unsigned PAD_W    = OUT_W - SAT_W;
  localparam int unsigned CNT_W    = 2;

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 << (SAT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(1 << (SAT_W - 1)));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    SAT_L = 2'd2,
    SAT_R = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic signed [SAMPLE_W-1:0] psg_l_q, psg_r_q, pcm_l_q, pcm_r_q;
  logic        [VOL_W-1:0]    psg_vol_q, pcm_vol_q;
  logic        [CNT_W-1:0]    term_q, bit_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [SAT_W-1:0]    left_hold_q;

  logic cap_en, mul_en, satl_en, satr_en, ovr_set;
  logic last_bit;

  logic signed [SAMPLE_W-1:0] cur_sample;
  logic        [VOL_W-1:0]    cur_vol;
  logic signed [ACC_W-1:0]    addend, acc_next, shifted;
  logic signed [SAT_W-1:0]    sat_val;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign last_bit = (bit_q == CNT_W'(VOL_W - 1));

  // Next-state logic: left pair ends after term 1, right pair after term 3
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (next_sample) state_d = MUL;
      MUL: begin
        if (last_bit && term_q == CNT_W'(1))      state_d = SAT_L;
        else if (last_bit && term_q == CNT_W'(3)) state_d = SAT_R;
      end
      SAT_L: state_d = MUL;
      SAT_R: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control strobes decoded from the current state
  always_comb begin
    cap_en  = 1'b0;
    mul_en  = 1'b0;
    satl_en = 1'b0;
    satr_en = 1'b0;
    ovr_set = 1'b0;
    unique case (state_q)
      IDLE:  cap_en  = next_sample;
      MUL:   mul_en  = 1'b1;
      SAT_L: satl_en = 1'b1;
      SAT_R: satr_en = 1'b1;
      default: ;
    endcase
    if (state_q != IDLE) ovr_set = next_sample;
  end

  // Term select: bit 0 picks PCM vs PSG, bit 1 picks right vs left
  always_comb begin
    unique case (term_q)
      2'd0:    cur_sample = psg_l_q;
      2'd1:    cur_sample = pcm_l_q;
      2'd2:    cur_sample = psg_r_q;
      default: cur_sample = pcm_r_q;
    endcase
    cur_vol  = term_q[0] ? pcm_vol_q : psg_vol_q;
    addend   = ACC_W'(cur_sample) <<< bit_q;
    acc_next = cur_vol[bit_q] ? (acc_q + addend) : acc_q;
  end

  // Scale back to unity gain, then clamp to the 17-bit output range
  always_comb begin
    shifted = acc_q >>> VOL_SHIFT;
    if (shifted > SAT_HI)      sat_val = SAT_W'(SAT_HI);
    else if (shifted < SAT_LO) sat_val = SAT_W'(SAT_LO);
    else                       sat_val = SAT_W'(shifted);
  end

  // Snapshot, counters and accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psg_l_q     <= '0;
      psg_r_q     <= '0;
      pcm_l_q     <= '0;
      pcm_r_q     <= '0;
      psg_vol_q   <= '0;
      pcm_vol_q   <= '0;
      term_q      <= '0;
      bit_q       <= '0;
      acc_q       <= '0;
      left_hold_q <= '0;
    end else begin
      if (cap_en) begin
        psg_l_q   <= psg_left;
        psg_r_q   <= psg_right;
        pcm_l_q   <= pcm_left;
        pcm_r_q   <= pcm_right;
        psg_vol_q <= psg_volume;
        pcm_vol_q <= pcm_volume;
        term_q    <= '0;
        bit_q     <= '0;
        acc_q     <= '0;
      end else if (mul_en) begin
        acc_q <= acc_next;
        bit_q <= bit_q + CNT_W'(1);
        if (last_bit) term_q <= term_q + CNT_W'(1);
      end else if (satl_en) begin
        left_hold_q <= sat_val;
        acc_q       <= '0;
      end
    end
  end

  // Registered outputs; both channels update together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_data    <= '0;
      right_data   <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= satr_en;
      if (satr_en) begin
        left_data  <= {left_hold_q, PAD_W'(0)};
        right_data <= {sat_val, PAD_W'(0)};
      end
      if (cap_en)       busy <= 1'b1;
      else if (satr_en) busy <= 1'b0;
      if (ovr_set)        overrun <= 1'b1;
      else if (ovr_clear) overrun <= 1'b0;
    end
  end

endmodule
